// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU control path: opcodes, sequencer
// states, datapath mux codes and the decoded control word.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_LDM = 4'h3;
  localparam logic [3:0] OP_STM = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JNZ = 4'h8;
  localparam logic [3:0] OP_JP  = 4'h9;
  localparam logic [3:0] OP_AND = 4'hA;
  localparam logic [3:0] OP_OR  = 4'hB;
  localparam logic [3:0] OP_ADD = 4'hC;
  localparam logic [3:0] OP_SUB = 4'hD;
  localparam logic [3:0] OP_UNA = 4'hE;
  localparam logic [3:0] OP_SYS = 4'hF;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_MEM    = 3'd2;
  localparam logic [2:0] ST_JABS   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [2:0] ASEL_ALU = 3'b000;
  localparam logic [2:0] ASEL_REG = 3'b001;
  localparam logic [2:0] ASEL_IN  = 3'b010;
  localparam logic [2:0] ASEL_MEM = 3'b011;
  localparam logic [2:0] ASEL_IMM = 3'b100;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_NOT  = 3'b101;
  localparam logic [2:0] ALU_INC  = 3'b110;
  localparam logic [2:0] ALU_DEC  = 3'b111;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SHL  = 2'b01;
  localparam logic [1:0] SH_SHR  = 2'b10;
  localparam logic [1:0] SH_ROTR = 2'b11;

  localparam logic [1:0] JMP_INC = 2'b00;
  localparam logic [1:0] JMP_ABS = 2'b01;
  localparam logic [1:0] JMP_REL = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_inst;
    logic       mem_wr;
    logic       ir_load;
    logic       pc_load;
    logic [1:0] jmp_mux;
    logic       mr_load;
    logic [2:0] a_sel;
    logic       a_load;
    logic       a_clr;
    logic       rf_wr;
    logic [2:0] alu_sel;
    logic [1:0] shft_sel;
    logic       out_en;
  } ctrl_t;

  function automatic logic jump_taken(input logic [3:0] op, input logic a_eq0,
                                      input logic a_pos);
    logic taken;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = a_eq0;
      OP_JNZ:  taken = !a_eq0;
      OP_JP:   taken = a_pos;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait counter: cleared by i_clr, counts while i_cnt, and flags the
// wait cycle on which the count would reach TIMEOUT.
module ctrl_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_cnt,
  output logic o_expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Wait-cycle counter, saturating at TIMEOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_cnt && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Expiry is flagged on the cycle whose increment makes the count TIMEOUT.
  assign o_expire = i_cnt && (r_cnt == CNT_LAST);

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/MEM/JABS/HALT control unit for the accumulator CPU,
// with illegal-opcode and memory time-out traps.
module ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int          IR_W        = 8,
  parameter int          RSEL_W      = 3,
  parameter int unsigned TIMEOUT     = 15,
  parameter int          HALT_RESUME = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IR_W-1:0] ir,
  input  logic            a_eq0,
  input  logic            a_pos,
  input  logic            mem_ack,
  input  logic            run,
  output logic            mem_req,
  output logic            mem_inst,
  output logic            mem_wr,
  output logic            ir_load,
  output logic            pc_load,
  output logic [1:0]      jmp_mux,
  output logic            mr_load,
  output logic [2:0]      a_sel,
  output logic            a_load,
  output logic            a_clr,
  output logic            rf_wr,
  output logic [2:0]      alu_sel,
  output logic [1:0]      shft_sel,
  output logic            out_en,
  output logic            halted,
  output logic            illegal,
  output logic            bus_err
);

  logic [2:0]      r_state;
  logic            r_illegal;
  logic            r_bus_err;
  logic [2:0]      w_state_nxt;
  logic            w_illegal_set;
  logic            w_bus_err_set;
  logic [3:0]      w_op;
  logic [3:0]      w_lo;
  logic [IR_W-5:0] w_rest;
  logic            w_rsv_bad;
  logic            w_taken;
  logic            w_mem_state;
  logic            w_expire;
  ctrl_t           w_ctrl;

  assign w_op        = ir[IR_W-1 -: 4];
  assign w_lo        = ir[3:0];
  assign w_rest      = ir[IR_W-5:0];
  // Register-addressed forms reserve the bits above the register field.
  assign w_rsv_bad   = |(w_rest >> RSEL_W);
  assign w_taken     = jump_taken(w_op, a_eq0, a_pos);
  assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_JABS) || (r_state == ST_MEM);

  ctrl_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (!w_mem_state || mem_ack),
    .i_cnt    (w_mem_state && !mem_ack),
    .o_expire (w_expire)
  );

  // Next-state and Moore control-word decode; strobes marked below are ack-qualified.
  always_comb begin
    w_ctrl        = '0;
    w_state_nxt   = r_state;
    w_illegal_set = 1'b0;
    w_bus_err_set = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_ctrl.mem_req  = 1'b1;
        w_ctrl.mem_inst = 1'b1;
        w_ctrl.jmp_mux  = JMP_INC;
        if (mem_ack) begin
          w_ctrl.ir_load = 1'b1;
          w_ctrl.pc_load = 1'b1;
          w_state_nxt    = ST_DECODE;
        end else if (w_expire) begin
          w_bus_err_set = 1'b1;
          w_state_nxt   = ST_HALT;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DECODE: begin
        w_state_nxt = ST_FETCH;
        case (w_op)
          OP_NOP: begin
            if (w_rest != '0) begin
              w_illegal_set = 1'b1;
              w_state_nxt   = ST_HALT;
            end else begin
              w_state_nxt = ST_FETCH;
            end
          end
          OP_LDA, OP_STA, OP_AND, OP_OR, OP_ADD, OP_SUB: begin
            if (w_rsv_bad) begin
              w_illegal_set = 1'b1;
              w_state_nxt   = ST_HALT;
            end else if (w_op == OP_LDA) begin
              w_ctrl.a_sel  = ASEL_REG;
              w_ctrl.a_load = 1'b1;
            end else if (w_op == OP_STA) begin
              w_ctrl.rf_wr = 1'b1;
            end else begin
              w_ctrl.a_sel  = ASEL_ALU;
              w_ctrl.a_load = 1'b1;
              case (w_op)
                OP_AND:  w_ctrl.alu_sel = ALU_AND;
                OP_OR:   w_ctrl.alu_sel = ALU_OR;
                OP_ADD:  w_ctrl.alu_sel = ALU_ADD;
                default: w_ctrl.alu_sel = ALU_SUB;
              endcase
            end
          end
          OP_LDI: begin
            w_ctrl.a_sel   = ASEL_IMM;
            w_ctrl.a_load  = 1'b1;
            w_ctrl.pc_load = 1'b1;
            w_ctrl.jmp_mux = JMP_INC;
          end
          OP_LDM, OP_STM: begin
            w_ctrl.mr_load = 1'b1;
            w_state_nxt    = ST_MEM;
          end
          OP_JMP, OP_JZ, OP_JNZ, OP_JP: begin
            if (w_lo == 4'h0) begin
              w_state_nxt = ST_JABS;
            end else if (w_taken) begin
              w_ctrl.pc_load = 1'b1;
              w_ctrl.jmp_mux = JMP_REL;
            end else begin
              w_state_nxt = ST_FETCH;
            end
          end
          OP_UNA: begin
            w_ctrl.a_load = 1'b1;
            case (w_lo)
              4'h0: w_ctrl.alu_sel  = ALU_NOT;
              4'h1: w_ctrl.alu_sel  = ALU_INC;
              4'h2: w_ctrl.alu_sel  = ALU_DEC;
              4'h3: w_ctrl.shft_sel = SH_SHL;
              4'h4: w_ctrl.shft_sel = SH_SHR;
              4'h5: w_ctrl.shft_sel = SH_ROTR;
              default: begin
                w_ctrl.a_load = 1'b0;
                w_illegal_set = 1'b1;
                w_state_nxt   = ST_HALT;
              end
            endcase
          end
          OP_SYS: begin
            case (w_lo)
              4'h0: begin
                w_ctrl.a_sel  = ASEL_IN;
                w_ctrl.a_load = 1'b1;
              end
              4'h1: w_ctrl.out_en = 1'b1;
              4'h2: w_state_nxt   = ST_HALT;
              default: begin
                w_illegal_set = 1'b1;
                w_state_nxt   = ST_HALT;
              end
            endcase
          end
          default: begin
            w_illegal_set = 1'b1;
            w_state_nxt   = ST_HALT;
          end
        endcase
      end
      ST_JABS: begin
        w_ctrl.mem_req  = 1'b1;
        w_ctrl.mem_inst = 1'b1;
        // A not-taken absolute jump still steps the PC past its operand word.
        w_ctrl.jmp_mux  = w_taken ? JMP_ABS : JMP_INC;
        if (mem_ack) begin
          w_ctrl.pc_load = 1'b1;
          w_state_nxt    = ST_FETCH;
        end else if (w_expire) begin
          w_bus_err_set = 1'b1;
          w_state_nxt   = ST_HALT;
        end else begin
          w_state_nxt = ST_JABS;
        end
      end
      ST_MEM: begin
        w_ctrl.mem_req  = 1'b1;
        w_ctrl.mem_inst = 1'b0;
        w_ctrl.mem_wr   = (w_op == OP_STM);
        w_ctrl.a_sel    = (w_op == OP_LDM) ? ASEL_MEM : ASEL_ALU;
        if (mem_ack) begin
          w_ctrl.a_load = (w_op == OP_LDM);
          w_state_nxt   = ST_FETCH;
        end else if (w_expire) begin
          w_bus_err_set = 1'b1;
          w_state_nxt   = ST_HALT;
        end else begin
          w_state_nxt = ST_MEM;
        end
      end
      ST_HALT: begin
        if ((HALT_RESUME != 0) && run) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_HALT;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // State register and sticky trap flags; only reset clears the flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_illegal <= r_illegal | w_illegal_set;
      r_bus_err <= r_bus_err | w_bus_err_set;
    end
  end

  // Reset forces every output low at once, so an in-flight mem_req drops asynchronously.
  assign mem_req  = w_ctrl.mem_req  & ~reset;
  assign mem_inst = w_ctrl.mem_inst & ~reset;
  assign mem_wr   = w_ctrl.mem_wr   & ~reset;
  assign ir_load  = w_ctrl.ir_load  & ~reset;
  assign pc_load  = w_ctrl.pc_load  & ~reset;
  assign jmp_mux  = w_ctrl.jmp_mux  & {2{~reset}};
  assign mr_load  = w_ctrl.mr_load  & ~reset;
  assign a_sel    = w_ctrl.a_sel    & {3{~reset}};
  assign a_load   = w_ctrl.a_load   & ~reset;
  assign a_clr    = w_ctrl.a_clr    & ~reset;
  assign rf_wr    = w_ctrl.rf_wr    & ~reset;
  assign alu_sel  = w_ctrl.alu_sel  & {3{~reset}};
  assign shft_sel = w_ctrl.shft_sel & {2{~reset}};
  assign out_en   = w_ctrl.out_en   & ~reset;
  assign halted   = (r_state == ST_HALT) & ~reset;
  assign illegal  = r_illegal & ~reset;
  assign bus_err  = r_bus_err & ~reset;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed-vector bench for ctrl_sequencer with default parameters (TIMEOUT=15).
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir;
  logic       a_eq0, a_pos, mem_ack, run;
  logic       mem_req, mem_inst, mem_wr, ir_load, pc_load, mr_load;
  logic [1:0] jmp_mux, shft_sel;
  logic [2:0] a_sel, alu_sel;
  logic       a_load, a_clr, rf_wr, out_en, halted, illegal, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ctrl_sequencer dut (
    .clk(clk), .reset(reset), .ir(ir), .a_eq0(a_eq0), .a_pos(a_pos),
    .mem_ack(mem_ack), .run(run), .mem_req(mem_req), .mem_inst(mem_inst),
    .mem_wr(mem_wr), .ir_load(ir_load), .pc_load(pc_load), .jmp_mux(jmp_mux),
    .mr_load(mr_load), .a_sel(a_sel), .a_load(a_load), .a_clr(a_clr),
    .rf_wr(rf_wr), .alu_sel(alu_sel), .shft_sel(shft_sel), .out_en(out_en),
    .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Moves to 2 time units after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Zero-wait FETCH of instr; returns in the following (DECODE) cycle with ack low.
  task automatic fetch_with(input logic [7:0] instr);
    mem_ack = 1'b1;
    ir      = instr;
    #1;
    chk("fetch_mem_req", mem_req, 8'd1);
    chk("fetch_mem_inst", mem_inst, 8'd1);
    chk("fetch_ir_load", ir_load, 8'd1);
    next_cycle();
    mem_ack = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; ir = 8'h00; a_eq0 = 1'b0; a_pos = 1'b0; mem_ack = 1'b0; run = 1'b0;
    #12;
    chk("rst_mem_req", mem_req, 8'd0);
    chk("rst_mem_inst", mem_inst, 8'd0);
    chk("rst_halted", halted, 8'd0);
    chk("rst_illegal", illegal, 8'd0);
    chk("rst_bus_err", bus_err, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_fetch", mem_req, 8'd1);

    // ADD r2, zero-wait
    mem_ack = 1'b1; ir = 8'hC2;
    #1;
    chk("add_fetch_pc_load", pc_load, 8'd1);
    chk("add_fetch_jmp_mux", jmp_mux, 8'd0);
    next_cycle();
    mem_ack = 1'b0;
    #1;
    chk("add_alu_sel", alu_sel, 8'd3);
    chk("add_a_load", a_load, 8'd1);
    chk("add_a_sel", a_sel, 8'd0);
    chk("add_dec_no_req", mem_req, 8'd0);
    next_cycle();

    // LDM with ack delayed 3 cycles
    fetch_with(8'h31);
    chk("ldm_mr_load", mr_load, 8'd1);
    next_cycle();
    #1;
    chk("ldm_w0_req", mem_req, 8'd1);
    chk("ldm_w0_inst", mem_inst, 8'd0);
    chk("ldm_w0_wr", mem_wr, 8'd0);
    chk("ldm_w0_a_load", a_load, 8'd0);
    for (int i = 1; i < 3; i++) begin
      next_cycle();
      #1;
      chk("ldm_wait_req", mem_req, 8'd1);
      chk("ldm_wait_a_load", a_load, 8'd0);
    end
    next_cycle();
    mem_ack = 1'b1;
    #1;
    chk("ldm_ack_req", mem_req, 8'd1);
    chk("ldm_ack_a_load", a_load, 8'd1);
    chk("ldm_ack_a_sel", a_sel, 8'd3);
    chk("ldm_ack_wr", mem_wr, 8'd0);
    next_cycle();
    mem_ack = 1'b0;

    // JZ absolute, taken then not taken
    for (int t = 0; t < 2; t++) begin
      a_eq0 = (t == 0);
      fetch_with(8'h70);
      chk("jz_dec_pc_load", pc_load, 8'd0);
      chk("jz_dec_req", mem_req, 8'd0);
      next_cycle();
      #1;
      chk("jz_jabs_req", mem_req, 8'd1);
      chk("jz_jabs_inst", mem_inst, 8'd1);
      chk("jz_jabs_noack_pc", pc_load, 8'd0);
      chk("jz_jabs_jmp_mux", jmp_mux, (t == 0) ? 8'd1 : 8'd0);
      mem_ack = 1'b1;
      #1;
      chk("jz_jabs_ack_pc", pc_load, 8'd1);
      chk("jz_jabs_ir_load", ir_load, 8'd0);
      next_cycle();
      mem_ack = 1'b0;
    end

    // JNZ relative: not taken (a_eq0=1), then taken (a_eq0=0)
    a_eq0 = 1'b1;
    fetch_with(8'h85);
    chk("jnzr_nt_pc_load", pc_load, 8'd0);
    next_cycle();
    a_eq0 = 1'b0;
    fetch_with(8'h85);
    chk("jnzr_t_pc_load", pc_load, 8'd1);
    chk("jnzr_t_jmp_mux", jmp_mux, 8'd2);
    next_cycle();

    // STM, zero-wait
    fetch_with(8'h42);
    chk("stm_mr_load", mr_load, 8'd1);
    next_cycle();
    mem_ack = 1'b1;
    #1;
    chk("stm_wr", mem_wr, 8'd1);
    chk("stm_inst", mem_inst, 8'd0);
    chk("stm_a_load", a_load, 8'd0);
    next_cycle();
    mem_ack = 1'b0;

    // SHR, OUT, LDI, STA
    fetch_with(8'hE4);
    chk("shr_shft_sel", shft_sel, 8'd2);
    chk("shr_a_load", a_load, 8'd1);
    chk("shr_alu_sel", alu_sel, 8'd0);
    next_cycle();
    fetch_with(8'hF1);
    chk("out_en", out_en, 8'd1);
    chk("out_a_load", a_load, 8'd0);
    next_cycle();
    fetch_with(8'h55);
    chk("ldi_a_sel", a_sel, 8'd4);
    chk("ldi_a_load", a_load, 8'd1);
    chk("ldi_pc_load", pc_load, 8'd1);
    next_cycle();
    fetch_with(8'h23);
    chk("sta_rf_wr", rf_wr, 8'd1);
    next_cycle();

    // HALT instruction and resume
    fetch_with(8'hF2);
    next_cycle();
    #1;
    chk("halt_halted", halted, 8'd1);
    chk("halt_no_illegal", illegal, 8'd0);
    chk("halt_no_req", mem_req, 8'd0);
    run = 1'b1;
    next_cycle();
    run = 1'b0;

    // Illegal E7
    fetch_with(8'hE7);
    chk("ill_dec_flag", illegal, 8'd0);
    chk("ill_dec_a_load", a_load, 8'd0);
    next_cycle();
    #1;
    chk("ill_illegal", illegal, 8'd1);
    chk("ill_halted", halted, 8'd1);
    next_cycle();
    #1;
    chk("ill_stay_halted", halted, 8'd1);
    run = 1'b1;
    next_cycle();
    run = 1'b0;
    #1;
    chk("ill_resume_halted", halted, 8'd0);
    chk("ill_resume_req", mem_req, 8'd1);
    chk("ill_sticky", illegal, 8'd1);

    // Memory time-out: 15 wait cycles in FETCH
    for (int i = 0; i < 15; i++) begin
      chk("to_wait_req", mem_req, 8'd1);
      chk("to_wait_bus_err", bus_err, 8'd0);
      next_cycle();
      #1;
    end
    chk("to_bus_err", bus_err, 8'd1);
    chk("to_halted", halted, 8'd1);
    chk("to_req_drop", mem_req, 8'd0);
    chk("to_illegal_kept", illegal, 8'd1);

    // Reset mid-wait clears all flags
    run = 1'b1;
    next_cycle();
    run = 1'b0;
    #1;
    chk("rmw_fetch_req", mem_req, 8'd1);
    chk("rmw_bus_err_kept", bus_err, 8'd1);
    next_cycle();
    reset = 1'b1;
    #1;
    chk("rmw_req_drop", mem_req, 8'd0);
    chk("rmw_bus_err", bus_err, 8'd0);
    chk("rmw_illegal", illegal, 8'd0);
    chk("rmw_halted", halted, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rmw_after_req", mem_req, 8'd1);
    chk("rmw_after_inst", mem_inst, 8'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
